// File: rtl/nes_pad_pkg.sv
// Purpose: shared types and constants for the NES pad poller (state encoding, button bit map).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: pad_state_t FSM encoding, BTN_* bit positions of the button word,
// PAD_BITS (8 buttons + presence bit), debounce_merge helper for NES_PAD_DEBOUNCE_EN builds.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_t;

  // Bit positions in the button word, matching the core's joypad emulation.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Eight buttons followed by the presence bit.
  localparam int PAD_BITS = 9;

  // Take a new bit only where two consecutive polls agree; elsewhere keep the held value.
  function automatic logic [7:0] debounce_merge(input logic [7:0] cur,
                                                input logic [7:0] prev,
                                                input logic [7:0] held);
    logic [7:0] agree;
    agree = ~(cur ^ prev);
    return (cur & agree) | (held & ~agree);
  endfunction

endpackage

// File: rtl/nes_pad_sync.sv
// Purpose: two-flop synchronizer for the asynchronous pad data line.
// Latency: 2 cycles from pin to d_sync.
// Backpressure: none; samples every cycle.
// Ports: clk_74a/reset_n (async active-low, resets to 1 = idle pull-up level),
//        d_in raw pin, d_sync synchronized output.
module nes_pad_sync (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic d_in,
  output logic d_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_in};
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_sync = sync_q[1];

endmodule

// File: rtl/nes_pad_poller.sv
// Purpose: polls a physical NES pad (latch/clock/data) and deserializes it into an 8-bit button word.
// Latency: 19*DIV cycles of pin activity per poll; valid pulses on cycle 19*DIV+1 after pad_latch rises.
// Backpressure: none; valid is a one-cycle pulse and buttons/pad_present hold until the next poll.
// Ports: clk_74a, reset_n (async active-low), enable (permits new polls), pad_data (async, low = pressed),
//        pad_latch / pad_clk (registered pad strobes), buttons {right,left,down,up,start,select,b,a},
//        pad_present (9th bit read low), valid.
// Build option: define NES_PAD_DEBOUNCE_EN to update a button only when two consecutive polls agree.
module nes_pad_poller
  import nes_pad_pkg::*;
#(
  parameter int DIV         = 446,
  parameter int POLL_CYCLES = 1_237_500
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       pad_present,
  output logic       valid
);

  localparam int HB_W = $clog2(DIV);
  localparam int PC_W = $clog2(POLL_CYCLES);
  localparam logic [HB_W-1:0] HB_RELOAD = HB_W'(DIV - 1);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(PAD_BITS - 1);

  pad_state_t      state_q, state_d;
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      raw_q, raw_d;
  logic            pad_latch_q, pad_latch_d;
  logic            pad_clk_q, pad_clk_d;
  logic [7:0]      buttons_q, buttons_d;
  logic            pad_present_q, pad_present_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0]      prev_raw_q, prev_raw_d;
`endif

  logic pad_sync;
  logic pressed;
  logic hb_done;
  logic expire;

  nes_pad_sync u_sync (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .d_in    (pad_data),
    .d_sync  (pad_sync)
  );

  assign pressed = ~pad_sync;
  assign hb_done = (hb_cnt_q == '0);
  assign expire  = (poll_cnt_q == POLL_LAST);

  always_comb begin
    state_d       = state_q;
    hb_cnt_d      = hb_done ? HB_RELOAD : hb_cnt_q - HB_W'(1);
    bit_cnt_d     = bit_cnt_q;
    raw_d         = raw_q;
    pad_latch_d   = pad_latch_q;
    pad_clk_d     = pad_clk_q;
    buttons_d     = buttons_q;
    pad_present_d = pad_present_q;
    valid_d       = 1'b0;
    poll_cnt_d    = expire ? '0 : poll_cnt_q + PC_W'(1);
    // A single pending request; further expiries while pending are absorbed.
    req_d         = req_q | expire;
`ifdef NES_PAD_DEBOUNCE_EN
    prev_raw_d    = prev_raw_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_q && enable) begin
          state_d     = LATCH;
          req_d       = expire;
          hb_cnt_d    = HB_RELOAD;
          bit_cnt_d   = '0;
          pad_latch_d = 1'b1;
        end
      end
      // The latch spans two half-bit periods; bit_cnt marks which one.
      LATCH: begin
        if (hb_done) begin
          if (bit_cnt_q != '0) begin
            state_d     = SETTLE;
            bit_cnt_d   = '0;
            pad_latch_d = 1'b0;
          end else begin
            bit_cnt_d = 4'd1;
          end
        end
      end
      SETTLE: begin
        if (hb_done) begin
          raw_d     = {pressed, raw_q[7:1]};
          bit_cnt_d = 4'd1;
          state_d   = CLK_LO;
          pad_clk_d = 1'b0;
        end
      end
      CLK_LO: begin
        if (hb_done) begin
          state_d   = CLK_HI;
          pad_clk_d = 1'b1;
        end
      end
      CLK_HI: begin
        if (hb_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            // Presence bit is taken live; raw_q already holds samples 0..7 in bit order.
            state_d       = DONE;
            valid_d       = 1'b1;
            pad_present_d = pressed;
`ifdef NES_PAD_DEBOUNCE_EN
            buttons_d  = pressed ? debounce_merge(raw_q, prev_raw_q, buttons_q) : 8'h00;
            prev_raw_d = pressed ? raw_q : 8'h00;
`else
            buttons_d  = pressed ? raw_q : 8'h00;
`endif
          end else begin
            raw_d     = {pressed, raw_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = CLK_LO;
            pad_clk_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hb_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      raw_q         <= '0;
      pad_latch_q   <= 1'b0;
      pad_clk_q     <= 1'b1;
      buttons_q     <= '0;
      pad_present_q <= 1'b0;
      valid_q       <= 1'b0;
      req_q         <= 1'b1;
      poll_cnt_q    <= '0;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_raw_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hb_cnt_q      <= hb_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      raw_q         <= raw_d;
      pad_latch_q   <= pad_latch_d;
      pad_clk_q     <= pad_clk_d;
      buttons_q     <= buttons_d;
      pad_present_q <= pad_present_d;
      valid_q       <= valid_d;
      req_q         <= req_d;
      poll_cnt_q    <= poll_cnt_d;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_raw_q    <= prev_raw_d;
`endif
    end
  end

  assign pad_latch   = pad_latch_q;
  assign pad_clk     = pad_clk_q;
  assign buttons     = buttons_q;
  assign pad_present = pad_present_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Purpose: directed self-checking bench for nes_pad_poller with a behavioural 4021 pad model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nes_pad_poller;
  import nes_pad_pkg::*;

  localparam int DIV       = 4;
  localparam int POLL      = 200;
  localparam int VALID_CYC = 19 * DIV + 1;

  typedef struct packed {
    logic [7:0] btn;
    logic       pres;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       pad_present;
  logic       valid;

  // Pad model: parallel load while latched, advance on each rising pad_clk.
  logic       pad_attached = 1'b0;
  logic [7:0] pad_press    = 8'h00;
  logic [3:0] pad_idx      = 4'd0;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];
  logic [7:0] m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0] m_prev = 8'h00;
`endif

  always #5 clk = ~clk;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_idx <= 4'd0;
    else if (pad_idx < 4'd9) pad_idx <= pad_idx + 4'd1;
  end

  assign pad_data = !pad_attached ? 1'b1 :
                    (pad_idx < 4'd8) ? ~pad_press[pad_idx[2:0]] :
                    (pad_idx == 4'd8) ? 1'b0 : 1'b1;

  nes_pad_poller #(.DIV(DIV), .POLL_CYCLES(POLL)) dut (
    .clk_74a     (clk),
    .reset_n     (rst_n),
    .enable      (enable),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .buttons     (buttons),
    .pad_present (pad_present),
    .valid       (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Configure the pad and push what the next completed poll must report.
  task automatic set_pad(input logic att, input logic [7:0] press);
    exp_t e;
    logic [7:0] raw;
    pad_attached = att;
    pad_press    = press;
    raw          = att ? press : 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
    if (!att) begin
      m_btn  = 8'h00;
      m_prev = 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) if (raw[i] == m_prev[i]) m_btn[i] = raw[i];
      m_prev = raw;
    end
`else
    m_btn = raw;
`endif
    e.btn  = m_btn;
    e.pres = att;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
    m_prev = 8'h00;
`endif
  endtask

  task automatic wait_rise(input string tag, output int rise);
    rise = -1;
    for (int n = 0; n < 2 * POLL; n++) begin
      tick();
      if (pad_latch) begin
        rise = cyc;
        break;
      end
    end
    check({tag, "_rise_seen"}, (rise >= 0) ? 1 : 0, 1);
  endtask

  // From the latch-rise cycle, run to valid; optionally drop enable at a given poll cycle.
  task automatic finish_poll(input string tag, input int rise, input int drop_at);
    int   len;
    int   vcyc;
    exp_t e;
    len  = 1;
    vcyc = -1;
    for (int n = 0; n < 2 * VALID_CYC; n++) begin
      if (drop_at > 0 && cyc == rise + drop_at - 1) enable = 1'b0;
      tick();
      if (pad_latch) len++;
      if (valid) begin
        vcyc = cyc;
        break;
      end
    end
    check({tag, "_latch_len"}, len, 2 * DIV);
    check({tag, "_valid_cycle"}, vcyc - rise + 1, VALID_CYC);
    check({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_buttons"}, {24'h0, buttons}, {24'h0, e.btn});
      check({tag, "_present"}, {31'h0, pad_present}, {31'h0, e.pres});
    end
    tick();
    check({tag, "_valid_pulse_end"}, {31'h0, valid}, 0);
  endtask

  initial begin
    int r1;
    int r2;
    int rises;
    logic prev_latch;

    enable = 1'b1;
    set_pad(1'b1, (8'h01 << BTN_A) | (8'h01 << BTN_START));
    #2 rst_n = 1'b0;
    #1;
    check("rst_latch", {31'h0, pad_latch}, 0);
    check("rst_clk", {31'h0, pad_clk}, 1);
    check("rst_buttons", {24'h0, buttons}, 0);
    check("rst_present", {31'h0, pad_present}, 0);
    check("rst_valid", {31'h0, valid}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("first_latch_rise", {31'h0, pad_latch}, 1);
    r1 = cyc;
    finish_poll("a_start_p1", r1, 0);

    // Same pad again; the following latch must rise one poll period later.
    set_pad(1'b1, (8'h01 << BTN_A) | (8'h01 << BTN_START));
    wait_rise("period", r2);
    check("poll_period", r2 - r1, POLL);
    finish_poll("a_start_p2", r2, 0);

    // No pad: data line pulled high.
    set_pad(1'b0, 8'h00);
    wait_rise("absent", r1);
    finish_poll("absent", r1, 0);

    // Right held over two polls.
    set_pad(1'b1, 8'h01 << BTN_RIGHT);
    wait_rise("right1", r1);
    finish_poll("right1", r1, 0);
    set_pad(1'b1, 8'h01 << BTN_RIGHT);
    wait_rise("right2", r1);
    finish_poll("right2", r1, 0);

    // Reset during CLK_LO of bit 4 (poll cycle 38).
    wait_rise("abort", r1);
    while (cyc < r1 + 37) tick();
    check("abort_in_clk_lo", {31'h0, pad_clk}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_latch", {31'h0, pad_latch}, 0);
    check("abort_clk", {31'h0, pad_clk}, 1);
    check("abort_buttons", {24'h0, buttons}, 0);
    check("abort_present", {31'h0, pad_present}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", {31'h0, valid}, 0);
    end
    model_reset();
    set_pad(1'b1, (8'h01 << BTN_B) | (8'h01 << BTN_UP));
    rst_n = 1'b1;
    tick();
    check("post_abort_rise", {31'h0, pad_latch}, 1);
    finish_poll("post_abort", cyc, 0);

    // Drop enable in SETTLE (poll cycle 10): that poll still completes.
    set_pad(1'b1, (8'h01 << BTN_B) | (8'h01 << BTN_UP));
    wait_rise("drop", r1);
    finish_poll("drop", r1, 10);
    rises = 0;
    prev_latch = pad_latch;
    for (int i = 0; i < 450; i++) begin
      tick();
      if (pad_latch && !prev_latch) rises++;
      prev_latch = pad_latch;
    end
    check("disabled_no_latch", rises, 0);

    // A request is pending; re-enabling starts a poll on the next cycle.
    set_pad(1'b1, (8'h01 << BTN_B) | (8'h01 << BTN_UP) | (8'h01 << BTN_SELECT));
    enable = 1'b1;
    tick();
    check("reenable_rise", {31'h0, pad_latch}, 1);
    finish_poll("reenable", cyc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
